ring_record_writer: RTL and testbench

- Successor to the fixed 11-channel point dumper. Captures a parametrised CHANNELS x DATA_W snapshot on a start strobe and writes it as one ROWS-word record into a single-port memory, one word per clock.
- Records go to a DEPTH-slot ring. Either an internal wrapping slot pointer or an external index selects the slot.
- Sits between the per-point computation datapath and the debug/readback RAM. It exposes the memory write port instead of instantiating the RAM.

---
 rtl/ring_record_writer.sv | 191 +++++++++++++++++++
 tb/tb_ring_record_writer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ring_record_writer.sv
// Ring record writer: snapshots CHANNELS words on start and
// writes them as one ROWS-word record into a DEPTH-slot ring.
module ring_record_writer #(
    parameter int CHANNELS = 11,
    parameter int DATA_W = 8,
    parameter int ROWS = 12,
    parameter int DEPTH = 1000,
    parameter int ADDR_W = 14,
    parameter int IDX_W = 10,
    parameter logic [DATA_W-1:0] PAD_VALUE = '0,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       use_index,
    input  logic [IDX_W-1:0]           slot_index,
    input  logic [CHANNELS*DATA_W-1:0] data_in,
    input  logic                       clear,
    output logic                       ready,
    output logic                       done,
    output logic                       err,
    output logic                       wrapped,
    output logic [PTR_W-1:0]           ring_ptr,
    output logic [15:0]                record_count,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    output logic                       mem_we
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ROWS_A = ADDR_W'(ROWS);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   snap_q [CHANNELS];
    logic [DATA_W-1:0]   snap_d [CHANNELS];
    logic [ROW_W-1:0]    row_q, row_d;
    logic                ext_q, ext_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [ADDR_W-1:0]   rbase_q, rbase_d;
    logic                wrap_q, wrap_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [ROW_W-1:0]    nrow;
    logic [DATA_W-1:0]   nword;
    logic [ADDR_W-1:0]   ext_base;
    logic                bad_idx;

    // Word for the following row: snapshot channel or pad.
    always_comb begin
        nrow  = row_q + ROW_W'(1);
        nword = PAD_VALUE;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ROW_W'(c) == nrow) nword = snap_q[c];
        end
    end

    // External slot base and range check.
    always_comb begin
        ext_base = ADDR_W'(slot_index) * ROWS_A;
        bad_idx  = 32'(slot_index) >= 32'(DEPTH);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        row_d   = row_q;
        ext_d   = ext_q;
        ptr_d   = ptr_q;
        rbase_d = rbase_q;
        wrap_d  = wrap_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                we_d    = 1'b0;
                ready_d = 1'b1;
                if (clear) begin
                    ptr_d   = '0;
                    rbase_d = '0;
                    wrap_d  = 1'b0;
                    cnt_d   = '0;
                end else if (start) begin
                    if (use_index && bad_idx) begin
                        err_d = 1'b1;
                    end else begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            snap_d[c] = data_in[c*DATA_W +: DATA_W];
                        end
                        state_d = WRITE;
                        ready_d = 1'b0;
                        ext_d   = use_index;
                        row_d   = '0;
                        we_d    = 1'b1;
                        addr_d  = use_index ? ext_base : rbase_q;
                        data_d  = data_in[DATA_W-1:0];
                    end
                end
            end
            WRITE: begin
                if (row_q == LAST_ROW) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    if (!ext_q) begin
                        if (ptr_q == LAST_PTR) begin
                            ptr_d   = '0;
                            rbase_d = '0;
                            wrap_d  = 1'b1;
                        end else begin
                            ptr_d   = ptr_q + PTR_W'(1);
                            rbase_d = rbase_q + ROWS_A;
                        end
                    end
                end else begin
                    row_d  = nrow;
                    addr_d = addr_q + ADDR_W'(1);
                    data_d = nword;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            ext_q   <= 1'b0;
            ptr_q   <= '0;
            rbase_q <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            ext_q   <= ext_d;
            ptr_q   <= ptr_d;
            rbase_q <= rbase_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Snapshot storage; only meaningful while writing.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign ready        = ready_q;
    assign done         = done_q;
    assign err          = err_q;
    assign wrapped      = wrap_q;
    assign ring_ptr     = ptr_q;
    assign record_count = cnt_q;
    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign mem_we       = we_q;

endmodule

// File: tb/tb_ring_record_writer.sv
// Randomized bench for ring_record_writer against a
// record-level queue model.
module tb_ring_record_writer;

    localparam int CH = 3;
    localparam int DW = 8;
    localparam int RW = 4;
    localparam int DP = 3;
    localparam int AW = 4;
    localparam int IW = 2;
    localparam logic [7:0] PAD = 8'hEE;

    logic          clk;
    logic          reset;
    logic          start;
    logic          use_index;
    logic [IW-1:0] slot_index;
    logic [23:0]   data_in;
    logic          clear;
    logic          ready, done, err, wrapped, mem_we;
    logic [1:0]    ring_ptr;
    logic [15:0]   record_count;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;

    ring_record_writer #(
        .CHANNELS(CH), .DATA_W(DW), .ROWS(RW), .DEPTH(DP),
        .ADDR_W(AW), .IDX_W(IW), .PAD_VALUE(PAD)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .use_index(use_index), .slot_index(slot_index),
        .data_in(data_in), .clear(clear), .ready(ready),
        .done(done), .err(err), .wrapped(wrapped),
        .ring_ptr(ring_ptr), .record_count(record_count),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int  m_ptr = 0;
    bit  m_wrap = 0;
    int  m_cnt = 0;
    bit  m_busy = 0;
    bit  m_ext = 0;
    int  qa[$];
    int  qd[$];
    bit  e_we = 0, e_done = 0, e_err = 0, e_ready = 1;
    bit  e_ad_valid = 0;
    int  e_addr = 0, e_data = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model();
        int base;
        logic [7:0] w;
        e_done = 0;
        e_err = 0;
        e_ad_valid = 0;
        if (reset) begin
            m_ptr = 0; m_wrap = 0; m_cnt = 0; m_busy = 0;
            qa.delete(); qd.delete();
            e_we = 0; e_ready = 1;
            e_addr = 0; e_data = 0; e_ad_valid = 1;
        end else if (m_busy) begin
            if (qa.size() > 0) begin
                e_we = 1;
                e_addr = qa.pop_front();
                e_data = qd.pop_front();
                e_ad_valid = 1;
            end else begin
                e_we = 0; e_done = 1; e_ready = 1; m_busy = 0;
                if (m_cnt < 65535) m_cnt++;
                if (!m_ext) begin
                    if (m_ptr == DP - 1) begin
                        m_ptr = 0; m_wrap = 1;
                    end else begin
                        m_ptr++;
                    end
                end
            end
        end else begin
            e_we = 0;
            e_ready = 1;
            if (clear) begin
                m_ptr = 0; m_wrap = 0; m_cnt = 0;
            end else if (start) begin
                if (use_index && int'(slot_index) >= DP) begin
                    e_err = 1;
                end else begin
                    base = (use_index ? int'(slot_index) : m_ptr) * RW;
                    for (int r = 0; r < RW; r++) begin
                        w = (r < CH) ? data_in[r*8 +: 8] : PAD;
                        qa.push_back((base + r) % 16);
                        qd.push_back(int'(w));
                    end
                    m_ext = use_index;
                    m_busy = 1;
                    e_ready = 0;
                    e_we = 1;
                    e_addr = qa.pop_front();
                    e_data = qd.pop_front();
                    e_ad_valid = 1;
                end
            end
        end
    endtask

    task automatic compare();
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("done", 32'(done), 32'(e_done));
        check("err", 32'(err), 32'(e_err));
        check("ready", 32'(ready), 32'(e_ready));
        check("ring_ptr", 32'(ring_ptr), 32'(m_ptr));
        check("wrapped", 32'(wrapped), 32'(m_wrap));
        check("record_count", 32'(record_count), 32'(m_cnt));
        if (e_ad_valid) begin
            check("mem_addr", 32'(mem_addr), 32'(e_addr));
            check("mem_data", 32'(mem_data), 32'(e_data));
        end
    endtask

    task automatic step(input logic st, input logic ui,
                        input logic [1:0] si, input logic [23:0] d,
                        input logic cl, input logic rs);
        start = st; use_index = ui; slot_index = si;
        data_in = d; clear = cl; reset = rs;
        @(posedge clk);
        model();
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 24'($urandom()), 0, 0);
    endtask

    initial begin
        clk = 0;
        start = 0; use_index = 0; slot_index = 0;
        data_in = 0; clear = 0; reset = 1;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        idle(1);
        // first internal record
        step(1, 0, 0, 24'h332211, 0, 0);
        idle(5);
        // three back-to-back internal records, wrap
        for (int i = 0; i < 15; i++) step(1, 0, 0, 24'($urandom()), 0, 0);
        idle(1);
        // external slot 2, then out-of-range slot 3
        step(1, 1, 2, 24'hC0B0A0, 0, 0);
        idle(5);
        step(1, 1, 3, 24'h123456, 0, 0);
        idle(2);
        // start during write with data changing
        step(1, 0, 0, 24'h665544, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 24'($urandom()), 0, 0);
        idle(3);
        // reset mid-record
        step(1, 0, 0, 24'h998877, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1);
        idle(2);
        // wrap, then clear together with start
        for (int i = 0; i < 15; i++) step(1, 0, 0, 24'($urandom()), 0, 0);
        step(1, 0, 0, 24'hABCDEF, 1, 0);
        idle(2);
        // clear during write is ignored
        step(1, 0, 0, 24'h0F0E0D, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 24'($urandom()), 1, 0);
        idle(3);
        // random phase
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) < 3,
                 2'($urandom_range(0, 3)),
                 24'($urandom()),
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 2);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
